// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues in-order imem requests, tracks DEPTH slots and presents the head.
// Accept->instr_valid is 2 cycles with 1-cycle memory; requests stop when all slots are allocated; the head is held by stall.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        pc_sel,
    input  logic [31:0] pc_nxt,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic [3:0]  queue_count
);
    localparam int            PW    = $clog2(DEPTH);
    localparam int            DW    = 6;
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [31:0]   NOP   = 32'h0000_0013;

    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_pc  [DEPTH];
    logic [31:0]      r_ins [DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW-1:0]    r_fill;
    logic [3:0]       r_count;
    logic [3:0]       r_pend;
    logic [DW-1:0]    r_drop;

    logic             w_accept;
    logic             w_pop;
    logic             w_fill;
    logic             w_drop_dec;
    logic             w_head_vld;
    logic [DW-1:0]    w_outstanding;
    logic [DW-1:0]    w_drop_ld;

    assign imem_req_valid = ~rst & ~pc_sel & (r_count < 4'(DEPTH));
    assign imem_req_addr  = {r_fetch_pc[31:2], 2'b00};
    assign w_accept       = imem_req_valid & imem_req_ready;

    assign w_head_vld  = r_filled[r_head] & ~rst;
    assign instr_valid = w_head_vld;
    assign instruction = w_head_vld ? r_ins[r_head] : NOP;
    assign pc_out      = rst ? 32'h0 : r_pc[r_head];
    assign queue_count = rst ? 4'h0 : r_count;

    assign w_pop      = w_head_vld & ~stall & ~pc_sel;
    assign w_fill     = imem_rsp_valid & ~pc_sel & (r_drop == '0) & (r_pend != '0);
    assign w_drop_dec = imem_rsp_valid & ~pc_sel & (r_drop != '0);

    // Everything still owed by memory after a redirect is stale; a response landing in the redirect cycle is one of them.
    assign w_outstanding = r_drop + DW'(r_pend);
    assign w_drop_ld     = (imem_rsp_valid && (w_outstanding != '0)) ? w_outstanding - DW'(1) : w_outstanding;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_filled   <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_fill     <= '0;
            r_count    <= '0;
            r_pend     <= '0;
            r_drop     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]  <= '0;
                r_ins[i] <= NOP;
            end
        end else if (pc_sel) begin
            r_fetch_pc <= pc_nxt;
            r_filled   <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_fill     <= '0;
            r_count    <= '0;
            r_pend     <= '0;
            r_drop     <= w_drop_ld;
        end else begin
            if (w_accept) begin
                r_fetch_pc       <= r_fetch_pc + 32'd4;
                r_pc[r_tail]     <= imem_req_addr;
                r_filled[r_tail] <= 1'b0;
                r_tail           <= r_tail + P_ONE;
            end
            // Fill walks allocation order independently of head, so pops never skip an unfilled slot.
            if (w_fill) begin
                r_ins[r_fill]    <= imem_rsp_data;
                r_filled[r_fill] <= 1'b1;
                r_fill           <= r_fill + P_ONE;
            end
            if (w_pop) begin
                r_filled[r_head] <= 1'b0;
                r_head           <= r_head + P_ONE;
            end
            r_count <= r_count + 4'(w_accept) - 4'(w_pop);
            r_pend  <= r_pend + 4'(w_accept) - 4'(w_fill);
            if (w_drop_dec) begin
                r_drop <= r_drop - DW'(1);
            end
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: in-order memory model with variable latency, expected
// instruction stream pushed on each accept and compared on each head pop.
module tb_ifetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        pc_sel;
    logic [31:0] pc_nxt;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [3:0]  queue_count;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .pc_sel         (pc_sel),
        .pc_nxt         (pc_nxt),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .pc_out         (pc_out),
        .queue_count    (queue_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    ent_t        sb[$];
    mreq_t       mq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_due = 0;
    logic [31:0] exp_pc = 32'h0;

    int          p_ready = 100;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          p_stall = 0;
    int          p_redir = 0;
    int          p_rst = 0;
    bit          rst_force = 1'b1;
    bit          do_redir = 1'b0;
    logic [31:0] redir_tgt = 32'h0;

    function automatic logic [31:0] image(input logic [31:0] a);
        return {a[31:16] ^ 16'hBEEF, a[15:0] ^ 16'h1357};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        int   lat;
        int   due;
        ent_t e;
        @(negedge clk);
        check("count", 32'(queue_count), sb.size());
        if (!instr_valid) check("nop", instruction, NOP);

        rst            = rst_force || ($urandom_range(999) < p_rst);
        stall          = ($urandom_range(99) < p_stall);
        pc_sel         = do_redir || ($urandom_range(99) < p_redir);
        pc_nxt         = do_redir ? redir_tgt : {14'h0, 16'($urandom), 2'b00};
        imem_req_ready = ($urandom_range(99) < p_ready);
        imem_rsp_data  = $urandom;
        imem_rsp_valid = 1'b0;
        if (rst) begin
            mq.delete();
            last_due = 0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = image(mq[0].addr);
            void'(mq.pop_front());
        end
        #1;

        if (rst) begin
            check("rst_req_vld", 32'(imem_req_valid), 32'h0);
            check("rst_instr_vld", 32'(instr_valid), 32'h0);
            check("rst_instr", instruction, NOP);
            check("rst_pc_out", pc_out, 32'h0);
            check("rst_count", 32'(queue_count), 32'h0);
            sb.delete();
            exp_pc = 32'h0;
        end else begin
            check("req_vld", 32'(imem_req_valid), 32'(!pc_sel && sb.size() < DEPTH));
            if (imem_req_valid) check("req_addr", imem_req_addr, exp_pc);
            if (instr_valid && !stall && !pc_sel) begin
                if (sb.size() == 0) begin
                    check("pop_extra", 32'(instr_valid), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("pop_pc", pc_out, e.pc);
                    check("pop_instr", instruction, e.ins);
                end
            end
            if (pc_sel) begin
                sb.delete();
                exp_pc = pc_nxt;
            end else if (imem_req_valid && imem_req_ready) begin
                sb.push_back({exp_pc, image(exp_pc)});
                exp_pc = exp_pc + 32'd4;
                lat = $urandom_range(lat_hi, lat_lo);
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq.push_back('{addr: imem_req_addr, due: due});
            end
        end
        cyc++;
    endtask

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        pc_sel         = 1'b0;
        pc_nxt         = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;

        repeat (3) step();
        rst_force = 1'b0;

        // Reset release with single-cycle memory: first valid two cycles later.
        for (int k = 0; k < 10; k++) begin
            step();
            check("lat_vld", 32'(instr_valid), 32'(k >= 2));
        end

        // Decode hold: queue fills, requests stop, head holds.
        p_stall = 100;
        repeat (6) step();
        check("stall_cnt", 32'(queue_count), DEPTH);
        check("stall_req", 32'(imem_req_valid), 32'h0);
        check("stall_pc", pc_out, sb[0].pc);
        check("stall_instr", instruction, sb[0].ins);
        p_stall = 0;
        repeat (10) step();

        // Three slow requests in flight, then redirect to 0x100.
        p_ready = 0;
        repeat (8) step();
        p_ready = 100;
        lat_lo  = 4;
        lat_hi  = 4;
        repeat (3) step();
        lat_lo    = 1;
        lat_hi    = 1;
        do_redir  = 1'b1;
        redir_tgt = 32'h0000_0100;
        step();
        do_redir = 1'b0;
        step();
        check("redir_addr", imem_req_addr, 32'h0000_0100);
        repeat (15) step();

        // Redirect together with stall while a response lands.
        p_stall = 100;
        repeat (2) step();
        do_redir  = 1'b1;
        redir_tgt = 32'h0000_0200;
        step();
        do_redir = 1'b0;
        step();
        check("redir_stall_cnt", 32'(queue_count), 32'h0);
        p_stall = 0;
        repeat (10) step();

        // Random traffic with redirects and occasional mid-run resets.
        p_ready = 50;
        lat_lo  = 1;
        lat_hi  = 4;
        p_stall = 30;
        p_redir = 3;
        p_rst   = 2;
        repeat (3000) step();

        // Drain: nothing may stay stuck in the queue.
        p_redir = 0;
        p_rst   = 0;
        p_stall = 0;
        p_ready = 0;
        repeat (20) step();
        check("drain_cnt", 32'(queue_count), 32'h0);
        check("drain_vld", 32'(instr_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction queue slots (power of two, 2..8).
REQ-002 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  decode hold; head entry SHALL NOT pop while high.
REQ-006 pc_sel  input  1  redirect request from execute (taken branch/jump).
REQ-007 pc_nxt  input  32  redirect target, sampled when pc_sel=1.
REQ-008 imem_req_valid  output  1  instruction-memory request valid.
REQ-009 imem_req_ready  input  1  memory accepts request this cycle.
REQ-010 imem_req_addr  output  32  request address (word aligned).
REQ-011 imem_rsp_valid  input  1  in-order response valid.
REQ-012 imem_rsp_data  input  32  response instruction word.
REQ-013 instr_valid  output  1  head slot holds a filled instruction.
REQ-014 instruction  output  32  head instruction; 32'h00000013 (NOP) when instr_valid=0.
REQ-015 pc_out  output  32  PC of head slot.
REQ-016 queue_count  output  4  allocated slots, 0..DEPTH.

Function
REQ-017 fetch_pc register SHALL drive imem_req_addr and SHALL increment by 4 on each accept (imem_req_valid & imem_req_ready).
REQ-018 imem_req_valid SHALL be 1 iff rst=0, pc_sel=0, and allocated slots < DEPTH; a pending request may be withdrawn only by pc_sel.
REQ-019 Each accept SHALL allocate the tail slot, storing fetch_pc with filled=0; allocated slots count both in-flight and filled entries.
REQ-020 Each accepted (non-discarded) response SHALL fill the oldest unfilled slot in allocation order; the fill is visible at the outputs the following cycle.
REQ-021 Head SHALL pop when instr_valid=1, stall=0, pc_sel=0; pop and allocate in the same cycle both take effect, count unchanged.
REQ-022 Latency: with 1-cycle memory, accept in cycle N -> response N+1 -> instr_valid in N+2; sustained throughput one instruction per cycle with stall=0.
REQ-023 On pc_sel=1: fetch_pc <= pc_nxt; all slots invalidated; head/tail/fill pointers and queue_count cleared; no pop; no request issued that cycle; stall ignored.
REQ-024 On pc_sel=1 a drop counter SHALL load the number of in-flight requests still outstanding after this cycle; a response arriving in the pc_sel cycle SHALL be discarded and not counted.
REQ-025 While drop counter > 0, each response SHALL be discarded and decrement the counter; new requests from cycle N+1 are permitted, and their responses fill slots only after the counter reaches 0.
REQ-026 Capacity rule: allocated slots + drop counter SHALL never exceed DEPTH + DEPTH; requests are gated only by allocated slots (REQ-018).
REQ-027 Response with no allocated unfilled slot and drop counter 0 SHALL be ignored.
REQ-028 Full queue: no allocate; head pop frees a slot, request may assert next cycle.
REQ-029 Pointers wrap modulo DEPTH.

Reset
REQ-030 While rst=1: fetch_pc=RESET_PC, pointers/counters/drop counter=0, all slots invalid, imem_req_valid=0, instr_valid=0, instruction=32'h00000013, pc_out=0, queue_count=0.
REQ-031 rst asserted mid-operation SHALL discard all in-flight state; responses for pre-reset requests arriving after rst deasserts are not tracked (memory SHALL be reset concurrently).

Verification
REQ-032 Reset release, ready=1, 1-cycle memory -> addr 0x0,0x4,0x8...; instr_valid rises 2 cycles after release, pc_out 0x0,0x4,0x8 consecutive cycles.
REQ-033 stall=1 held 6 cycles -> queue_count reaches 4, imem_req_valid=0, head pc/instruction unchanged; stall=0 -> pops resume, no instruction lost or duplicated.
REQ-034 Three requests in flight, pc_sel=1 pc_nxt=0x100 -> next accepted addr 0x100; three stale responses discarded; first instr_valid shows pc_out=0x100.
REQ-035 pc_sel and stall both 1 with a response arriving same cycle -> redirect taken, response discarded, queue_count=0 next cycle.
REQ-036 Random ready (50%) and 1-4 cycle response latency, random stall -> output stream equals memory image in PC order, instruction=0x13 whenever instr_valid=0.
